// File: rtl/fifo_pump_pkg.sv
// Shared types and helpers for the h2f_out -> f2h_in FIFO pump.
package fifo_pump_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_SRC_LVL,
    RD_DST_LVL,
    CALC,
    RD_DATA,
    WR_DATA,
    ERROR
  } state_t;

  function automatic logic [WORD_W-1:0] min3(input logic [WORD_W-1:0] a,
                                             input logic [WORD_W-1:0] b,
                                             input logic [WORD_W-1:0] c);
    logic [WORD_W-1:0] m;
    m = (a < b) ? a : b;
    m = (m < c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/mm_access_port.sv
// One memory-mapped master request slot: holds a single read or write until
// acknowledge, and gives up after TIMEOUT cycles without one.
module mm_access_port
  import fifo_pump_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              start,
  input  logic              start_write,
  input  logic [ADDR_W-1:0] start_address,
  input  logic [WORD_W-1:0] start_write_data,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byte_enable,
  output logic              read,
  output logic              write,
  output logic [WORD_W-1:0] write_data,
  input  logic              acknowledge,
  input  logic [WORD_W-1:0] read_data,
  output logic              pending,
  output logic              done,
  output logic              timeout,
  output logic [WORD_W-1:0] rdata
);

  localparam int TMR_W = 10;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic              pending_reg;
  logic [TMR_W-1:0]  timer_reg;
  logic [ADDR_W-1:0] address_reg;
  logic [3:0]        byte_enable_reg;
  logic              read_reg;
  logic              write_reg;
  logic [WORD_W-1:0] write_data_reg;

  // An acknowledge in the last allowed cycle still counts as a completed access.
  assign done    = pending_reg & acknowledge;
  assign timeout = pending_reg & ~acknowledge & (timer_reg == TMR_LAST);
  assign rdata   = read_data;
  assign pending = pending_reg;

  assign address     = address_reg;
  assign byte_enable = byte_enable_reg;
  assign read        = read_reg;
  assign write       = write_reg;
  assign write_data  = write_data_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      pending_reg     <= 1'b0;
      timer_reg       <= '0;
      address_reg     <= '0;
      byte_enable_reg <= 4'h0;
      read_reg        <= 1'b0;
      write_reg       <= 1'b0;
      write_data_reg  <= '0;
    end else if (pending_reg) begin
      if (acknowledge || (timer_reg == TMR_LAST)) begin
        pending_reg     <= 1'b0;
        address_reg     <= '0;
        byte_enable_reg <= 4'h0;
        read_reg        <= 1'b0;
        write_reg       <= 1'b0;
        write_data_reg  <= '0;
      end else begin
        timer_reg <= timer_reg + TMR_W'(1);
      end
    end else if (start) begin
      pending_reg     <= 1'b1;
      timer_reg       <= '0;
      address_reg     <= start_address;
      byte_enable_reg <= 4'hF;
      read_reg        <= ~start_write;
      write_reg       <= start_write;
      write_data_reg  <= start_write ? start_write_data : '0;
    end
  end

endmodule

// File: rtl/fifo_pump_ctrl.sv
// Sequencer that polls both FIFO fill levels and moves bounded bursts of words
// from h2f_out to f2h_in, one read/write pair at a time.
module fifo_pump_ctrl
  import fifo_pump_pkg::*;
#(
  parameter logic [5:0] SRC_DATA_ADDR  = 6'h00,
  parameter logic [5:0] SRC_LEVEL_ADDR = 6'h20,
  parameter logic [2:0] DST_DATA_ADDR  = 3'h0,
  parameter logic [2:0] DST_LEVEL_ADDR = 3'h4,
  parameter int         DST_DEPTH      = 256,
  parameter int         MAX_BURST      = 16,
  parameter int         TIMEOUT        = 1023
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        enable,
  input  logic        clear_error,
  output logic [5:0]  src_address,
  output logic [3:0]  src_byte_enable,
  output logic        src_read,
  output logic        src_write,
  output logic [31:0] src_write_data,
  input  logic        src_acknowledge,
  input  logic [31:0] src_read_data,
  output logic [2:0]  dst_address,
  output logic [3:0]  dst_byte_enable,
  output logic        dst_read,
  output logic        dst_write,
  output logic [31:0] dst_write_data,
  input  logic        dst_acknowledge,
  input  logic [31:0] dst_read_data,
  output logic        busy,
  output logic        error,
  output logic [31:0] words_moved
);

  state_t            state_reg;
  logic [WORD_W-1:0] src_lvl_reg;
  logic [WORD_W-1:0] free_reg;
  logic [WORD_W-1:0] remaining_reg;
  logic [WORD_W-1:0] hold_reg;
  logic [WORD_W-1:0] words_moved_reg;
  logic              busy_reg;
  logic              error_reg;

  logic              src_start, src_pending, src_done, src_timeout;
  logic [5:0]        src_start_address;
  logic [WORD_W-1:0] src_rdata;
  logic              dst_start, dst_start_write, dst_pending, dst_done, dst_timeout;
  logic [2:0]        dst_start_address;
  logic [WORD_W-1:0] dst_rdata;
  logic [WORD_W-1:0] burst;

  assign burst = min3(src_lvl_reg, free_reg, WORD_W'(MAX_BURST));

  // Each access state issues exactly one request once its port is free.
  always_comb begin
    src_start         = 1'b0;
    src_start_address = SRC_LEVEL_ADDR;
    dst_start         = 1'b0;
    dst_start_write   = 1'b0;
    dst_start_address = DST_LEVEL_ADDR;
    case (state_reg)
      RD_SRC_LVL: src_start = ~src_pending;
      RD_DST_LVL: dst_start = ~dst_pending;
      RD_DATA: begin
        src_start         = ~src_pending;
        src_start_address = SRC_DATA_ADDR;
      end
      WR_DATA: begin
        dst_start         = ~dst_pending;
        dst_start_write   = 1'b1;
        dst_start_address = DST_DATA_ADDR;
      end
      default: ;
    endcase
  end

  mm_access_port #(.ADDR_W(6), .TIMEOUT(TIMEOUT)) u_src_port (
    .clk              (clk_clk),
    .srst             (reset_reset),
    .start            (src_start),
    .start_write      (1'b0),
    .start_address    (src_start_address),
    .start_write_data ('0),
    .address          (src_address),
    .byte_enable      (src_byte_enable),
    .read             (src_read),
    .write            (src_write),
    .write_data       (src_write_data),
    .acknowledge      (src_acknowledge),
    .read_data        (src_read_data),
    .pending          (src_pending),
    .done             (src_done),
    .timeout          (src_timeout),
    .rdata            (src_rdata)
  );

  mm_access_port #(.ADDR_W(3), .TIMEOUT(TIMEOUT)) u_dst_port (
    .clk              (clk_clk),
    .srst             (reset_reset),
    .start            (dst_start),
    .start_write      (dst_start_write),
    .start_address    (dst_start_address),
    .start_write_data (hold_reg),
    .address          (dst_address),
    .byte_enable      (dst_byte_enable),
    .read             (dst_read),
    .write            (dst_write),
    .write_data       (dst_write_data),
    .acknowledge      (dst_acknowledge),
    .read_data        (dst_read_data),
    .pending          (dst_pending),
    .done             (dst_done),
    .timeout          (dst_timeout),
    .rdata            (dst_rdata)
  );

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_reg       <= IDLE;
      src_lvl_reg     <= '0;
      free_reg        <= '0;
      remaining_reg   <= '0;
      hold_reg        <= '0;
      words_moved_reg <= '0;
      busy_reg        <= 1'b0;
      error_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (enable) begin
            state_reg <= RD_SRC_LVL;
            busy_reg  <= 1'b1;
          end
        end
        RD_SRC_LVL: begin
          if (src_done) begin
            src_lvl_reg <= src_rdata;
            if (src_rdata == '0) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= RD_DST_LVL;
            end
          end else if (src_timeout) begin
            state_reg <= ERROR;
            error_reg <= 1'b1;
          end
        end
        RD_DST_LVL: begin
          if (dst_done) begin
            // An over-reported level means no room rather than a wrapped count.
            free_reg  <= (dst_rdata > WORD_W'(DST_DEPTH)) ? '0 : WORD_W'(DST_DEPTH) - dst_rdata;
            state_reg <= CALC;
          end else if (dst_timeout) begin
            state_reg <= ERROR;
            error_reg <= 1'b1;
          end
        end
        CALC: begin
          if (burst == '0) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            remaining_reg <= burst;
            state_reg     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (src_done) begin
            hold_reg  <= src_rdata;
            state_reg <= WR_DATA;
          end else if (src_timeout) begin
            state_reg <= ERROR;
            error_reg <= 1'b1;
          end
        end
        WR_DATA: begin
          if (dst_done) begin
            words_moved_reg <= words_moved_reg + 32'd1;
            remaining_reg   <= remaining_reg - 32'd1;
            // enable is only honoured here so a word already read is always written.
            if ((remaining_reg == 32'd1) || !enable) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= RD_DATA;
            end
          end else if (dst_timeout) begin
            state_reg <= ERROR;
            error_reg <= 1'b1;
          end
        end
        ERROR: begin
          if (clear_error) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            error_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          error_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_reg;
  assign error       = error_reg;
  assign words_moved = words_moved_reg;

endmodule

// File: tb/tb_fifo_pump_ctrl.sv
// Directed bench for fifo_pump_ctrl with behavioural FIFO slave models.
module tb_fifo_pump_ctrl;

  localparam int TMO = 20;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        enable;
  logic        clear_error;
  logic [5:0]  src_address;
  logic [3:0]  src_byte_enable;
  logic        src_read;
  logic        src_write;
  logic [31:0] src_write_data;
  logic        src_acknowledge;
  logic [31:0] src_read_data;
  logic [2:0]  dst_address;
  logic [3:0]  dst_byte_enable;
  logic        dst_read;
  logic        dst_write;
  logic [31:0] dst_write_data;
  logic        dst_acknowledge;
  logic [31:0] dst_read_data;
  logic        busy;
  logic        error;
  logic [31:0] words_moved;

  fifo_pump_ctrl #(.TIMEOUT(TMO)) dut (
    .clk_clk         (clk_clk),
    .reset_reset     (reset_reset),
    .enable          (enable),
    .clear_error     (clear_error),
    .src_address     (src_address),
    .src_byte_enable (src_byte_enable),
    .src_read        (src_read),
    .src_write       (src_write),
    .src_write_data  (src_write_data),
    .src_acknowledge (src_acknowledge),
    .src_read_data   (src_read_data),
    .dst_address     (dst_address),
    .dst_byte_enable (dst_byte_enable),
    .dst_read        (dst_read),
    .dst_write       (dst_write),
    .dst_write_data  (dst_write_data),
    .dst_acknowledge (dst_acknowledge),
    .dst_read_data   (dst_read_data),
    .busy            (busy),
    .error           (error),
    .words_moved     (words_moved)
  );

  always #5 clk_clk = ~clk_clk;

  int checks = 0;
  int errors = 0;

  // FIFO models and activity counters
  int          src_level_m = 0;
  int          dst_level_m = 0;
  int          src_lat = 1;
  int          dst_lat = 1;
  bit          dst_wr_never = 1'b0;
  logic [31:0] seq = 32'hA5A5_0000;
  logic [31:0] exp_q[$];
  int          src_lvl_reads = 0;
  int          src_data_reqs = 0;
  int          dst_writes = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // h2f_out slave: acknowledges after src_lat request cycles
  initial begin
    int wait_c;
    wait_c = 0;
    src_acknowledge = 1'b0;
    src_read_data = '0;
    forever begin
      @(negedge clk_clk);
      if (src_acknowledge || reset_reset || !src_read) begin
        src_acknowledge = 1'b0;
        wait_c = 0;
      end else begin
        if (wait_c == 0) begin
          check("src_be", {28'd0, src_byte_enable}, 32'hF);
          if (src_address == 6'h00) src_data_reqs++;
        end
        wait_c++;
        if (wait_c >= src_lat) begin
          src_acknowledge = 1'b1;
          if (src_address == 6'h20) begin
            src_read_data = src_level_m;
            src_lvl_reads++;
          end else begin
            src_read_data = seq;
            exp_q.push_back(seq);
            seq++;
            if (src_level_m > 0) src_level_m--;
          end
        end
      end
    end
  end

  // f2h_in slave: level reads return dst_level_m, writes are checked in order
  initial begin
    int wait_c;
    logic [31:0] exp_w;
    wait_c = 0;
    dst_acknowledge = 1'b0;
    dst_read_data = '0;
    forever begin
      @(negedge clk_clk);
      if (dst_acknowledge || reset_reset || !(dst_read || dst_write)) begin
        dst_acknowledge = 1'b0;
        wait_c = 0;
      end else begin
        wait_c++;
        if (wait_c >= dst_lat && !(dst_write && dst_wr_never)) begin
          dst_acknowledge = 1'b1;
          if (dst_write) begin
            exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            check("wdata", dst_write_data, exp_w);
            dst_level_m++;
            dst_writes++;
          end else begin
            dst_read_data = dst_level_m;
          end
        end
      end
    end
  end

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk_clk);
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int base;
    int r0;
    int d0;
    int w0;
    reset_reset = 1'b1;
    enable = 1'b0;
    clear_error = 1'b0;
    repeat (3) @(negedge clk_clk);
    check("rst_src_read", {31'd0, src_read}, 0);
    check("rst_dst_wr", {30'd0, dst_read, dst_write}, 0);
    check("rst_busy_err", {30'd0, busy, error}, 0);
    check("rst_words", words_moved, 0);
    check("rst_be", {24'd0, src_byte_enable, dst_byte_enable}, 0);
    reset_reset = 1'b0;
    @(negedge clk_clk);

    // 3 words, latency 1, single-word latency measured
    src_level_m = 3;
    dst_level_m = 0;
    enable = 1'b1;
    n = 0;
    while (!busy && n < 10) begin @(negedge clk_clk); n++; end
    n = 0;
    while (words_moved == 0 && n < 50) begin @(negedge clk_clk); n++; end
    check("first_word_lat", n, 9);
    n = 0;
    while (words_moved < 3 && n < 200) begin @(negedge clk_clk); n++; end
    repeat (30) @(negedge clk_clk);
    check("t1_words", words_moved, 3);
    check("t1_writes", dst_writes, 3);
    enable = 1'b0;
    wait_idle("t1_idle");

    // free=6 limits the burst, then polling continues
    src_level_m = 40;
    dst_level_m = 250;
    base = words_moved;
    r0 = src_lvl_reads;
    enable = 1'b1;
    repeat (200) @(negedge clk_clk);
    check("t2_words", words_moved - base, 6);
    check("t2_repoll", (src_lvl_reads - r0) >= 3, 1);
    enable = 1'b0;
    wait_idle("t2_idle");

    // empty source: only level polling
    src_level_m = 0;
    dst_level_m = 0;
    base = words_moved;
    r0 = src_lvl_reads;
    d0 = src_data_reqs;
    enable = 1'b1;
    repeat (40) @(negedge clk_clk);
    check("t3_no_data", src_data_reqs - d0, 0);
    check("t3_polls", (src_lvl_reads - r0) >= 10, 1);
    check("t3_words", words_moved - base, 0);
    enable = 1'b0;
    wait_idle("t3_idle");

    // acknowledge in the last allowed cycle beats the timeout
    src_level_m = 1;
    dst_lat = TMO;
    base = words_moved;
    enable = 1'b1;
    n = 0;
    while (words_moved == base && n < 400) begin @(negedge clk_clk); n++; end
    check("t4_words", words_moved - base, 1);
    check("t4_no_err", {31'd0, error}, 0);
    enable = 1'b0;
    wait_idle("t4_idle");

    // write never acknowledged -> timeout and ERROR
    dst_lat = 1;
    dst_wr_never = 1'b1;
    src_level_m = 1;
    base = words_moved;
    enable = 1'b1;
    n = 0;
    while (!dst_write && n < 100) begin @(negedge clk_clk); n++; end
    n = 0;
    while (dst_write && n < 100) begin @(negedge clk_clk); n++; end
    check("t5_wr_cycles", n, TMO);
    check("t5_error", {31'd0, error}, 1);
    enable = 1'b0;
    repeat (3) @(negedge clk_clk);
    check("t5_err_held", {30'd0, error, busy}, 2'b11);
    clear_error = 1'b1;
    @(negedge clk_clk);
    clear_error = 1'b0;
    check("t5_cleared", {30'd0, error, busy}, 0);
    check("t5_words_kept", words_moved, base);
    dst_wr_never = 1'b0;
    exp_q.delete();

    // enable drops during the read of word 2 of 5
    src_level_m = 5;
    dst_level_m = 0;
    src_lat = 3;
    base = words_moved;
    w0 = dst_writes;
    d0 = src_data_reqs;
    enable = 1'b1;
    n = 0;
    while (src_data_reqs - d0 < 2 && n < 200) begin @(negedge clk_clk); n++; end
    enable = 1'b0;
    wait_idle("t6_idle");
    check("t6_words", words_moved - base, 2);
    check("t6_writes", dst_writes - w0, 2);

    // reset while a source read is pending
    src_lat = 5;
    enable = 1'b1;
    n = 0;
    while (!src_read && n < 50) begin @(negedge clk_clk); n++; end
    check("t7_pending", {31'd0, src_read}, 1);
    enable = 1'b0;
    reset_reset = 1'b1;
    @(negedge clk_clk);
    reset_reset = 1'b0;
    check("t7_req_drop", {29'd0, src_read, dst_read, dst_write}, 0);
    check("t7_words", words_moved, 0);
    check("t7_idle", {30'd0, busy, error}, 0);

    // controller works again after reset
    src_lat = 1;
    src_level_m = 1;
    exp_q.delete();
    enable = 1'b1;
    n = 0;
    while (words_moved == 0 && n < 100) begin @(negedge clk_clk); n++; end
    check("t7_restart", words_moved, 1);
    enable = 1'b0;
    wait_idle("t7_end_idle");
    check("src_write_zero", {31'd0, src_write}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
